// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 32x32 register file: WB has priority, MDU results queue in a FIFO.
// Optional REGFILE_ARB_BYPASS_EN lets an MDU result skip the empty FIFO when WB is idle.
module regfile_write_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wb_valid,
  input  logic [4:0]                 wb_reg,
  input  logic [31:0]                wb_data,
  output logic                       wb_stall,
  input  logic                       mdu_valid,
  output logic                       mdu_ready,
  input  logic [4:0]                 mdu_reg,
  input  logic [31:0]                mdu_data,
  input  logic [4:0]                 pend_reg,
  output logic                       pend_hit,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       RegWrite,
  output logic [4:0]                 WriteReg,
  output logic [31:0]                WriteData
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    fifo_reg  [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic          empty;
  logic          grant_wb;
  logic          pop;
  logic          push;
  logic          bypass;
  logic          grant_valid;
  logic [4:0]    grant_reg;
  logic [31:0]   grant_data;
  logic          fifo_hit;

  assign empty      = (count == '0);
  assign mdu_ready  = (count != CW'(DEPTH));
  assign fifo_count = count;
  assign wb_stall   = !empty && (starve_cnt == SW'(STARVE_MAX));
  assign grant_wb   = wb_valid && !wb_stall;
  assign pop        = !grant_wb && !empty;

`ifdef REGFILE_ARB_BYPASS_EN
  // An empty FIFO can never stall WB, so !grant_wb here already means WB is idle.
  assign bypass = !grant_wb && empty && mdu_valid;
`else
  assign bypass = 1'b0;
`endif

  assign push = mdu_valid && mdu_ready && !bypass;

  always_comb begin
    grant_valid = 1'b0;
    grant_reg   = '0;
    grant_data  = '0;
    if (grant_wb) begin
      grant_valid = 1'b1;
      grant_reg   = wb_reg;
      grant_data  = wb_data;
    end else if (pop) begin
      grant_valid = 1'b1;
      grant_reg   = fifo_reg[rd_ptr];
      grant_data  = fifo_data[rd_ptr];
    end else if (bypass) begin
      grant_valid = 1'b1;
      grant_reg   = mdu_reg;
      grant_data  = mdu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr]  <= mdu_reg;
      fifo_data[wr_ptr] <= mdu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (grant_wb) begin
        if (!empty) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  // Register-0 writes still consume their grant but never reach the register file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else begin
      RegWrite  <= grant_valid && (grant_reg != '0);
      WriteReg  <= grant_reg;
      WriteData <= grant_data;
    end
  end

  always_comb begin
    fifo_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (fifo_reg[rd_ptr + PW'(i)] == pend_reg)) fifo_hit = 1'b1;
    end
  end

  assign pend_hit = (pend_reg != '0) && (fifo_hit || (RegWrite && (WriteReg == pend_reg)));

endmodule
